// File: rtl/aesha_input_loader_pkg.sv
// Shared constants and types for the AESHA input loader slice.
package aesha_pkg;

  // Host word address map
  localparam logic [4:0] KEY_BASE  = 5'd0;
  localparam logic [4:0] DATA_BASE = 5'd4;
  localparam logic [4:0] CTRL_ADDR = 5'd20;

  // Bit positions inside the control word
  localparam int CTRL_AES_BIT = 0;
  localparam int CTRL_DEC_BIT = 1;

  // Default operation lengths, counted from control-unit reset release
  localparam int DEF_KECCAK_CYCLES = 26;
  localparam int DEF_AES_CYCLES    = 44;

  // Launch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/aesha_input_loader_if.sv
// Host-side bus of the AESHA input loader.
//
// Handshake: i_wr_en and i_start are valid strobes with an implicit
// ready of 1. Every strobe is consumed in the cycle it is presented;
// a strobe that cannot be honoured is dropped and flagged by a
// one-cycle o_wr_err pulse on the following cycle. There is no
// backpressure.
interface aesha_input_loader_if;
  logic        i_wr_en;
  logic [4:0]  i_wr_addr;
  logic [31:0] i_wr_data;
  logic        i_start;
  logic        o_busy;
  logic        o_done;
  logic        o_wr_err;

  modport master (
    output i_wr_en, i_wr_addr, i_wr_data, i_start,
    input  o_busy, o_done, o_wr_err
  );

  modport slave (
    input  i_wr_en, i_wr_addr, i_wr_data, i_start,
    output o_busy, o_done, o_wr_err
  );
endinterface

// File: rtl/aesha_wr_decode.sv
// Combinational host address decoder: one-hot word enables plus an
// illegal-address flag for writes outside the map.
module aesha_wr_decode
  import aesha_pkg::*;
#(
  parameter int KEY_WORDS  = 4,
  parameter int DATA_WORDS = 16
) (
  input  logic                  wr_en,
  input  logic [4:0]            wr_addr,
  output logic [KEY_WORDS-1:0]  key_we,
  output logic [DATA_WORDS-1:0] data_we,
  output logic                  ctrl_we,
  output logic                  illegal
);

  // Compare the address against each mapped word; anything unmatched is illegal
  always_comb begin
    key_we  = '0;
    data_we = '0;
    ctrl_we = 1'b0;
    illegal = 1'b0;
    for (int k = 0; k < KEY_WORDS; k++) begin
      key_we[k] = wr_en && (wr_addr == 5'(KEY_BASE + k));
    end
    for (int j = 0; j < DATA_WORDS; j++) begin
      data_we[j] = wr_en && (wr_addr == 5'(DATA_BASE + j));
    end
    ctrl_we = wr_en && (wr_addr == CTRL_ADDR);
    illegal = wr_en && !((|key_we) || (|data_we) || ctrl_we);
  end

endmodule

// File: rtl/aesha_input_loader.sv
// Loads key/data/mode from 32-bit host writes, launches one control-unit
// operation by releasing its active-low reset, and times the run.
module aesha_input_loader
  import aesha_pkg::*;
#(
  parameter int DATA_WORDS    = 16,
  parameter int KEY_WORDS     = 4,
  parameter int KECCAK_CYCLES = DEF_KECCAK_CYCLES,
  parameter int AES_CYCLES    = DEF_AES_CYCLES
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  aesha_input_loader_if.slave     host,
  output logic [32*KEY_WORDS-1:0] o_key,
  output logic [32*DATA_WORDS-1:0] o_data,
  output logic                    o_aes_or_keccak,
  output logic                    o_enc_or_dec,
  output logic                    o_cu_reset_n,
  output state_t                  o_state
);

  localparam int CW = $clog2(max_int(AES_CYCLES, KECCAK_CYCLES));

  logic [32*KEY_WORDS-1:0]  key_q;
  logic [32*DATA_WORDS-1:0] data_q;
  logic                     aes_q, dec_q;
  logic                     start_q, cu_rst_n_q, busy_q, err_q;
  logic [CW-1:0]            cnt_q;
  state_t                   state_q, state_d;

  logic [KEY_WORDS-1:0]  key_we;
  logic [DATA_WORDS-1:0] data_we;
  logic                  ctrl_we, illegal;
  logic                  in_idle, start_rise, launch, reject, aes_eff;
  logic                  busy_d, done;

  aesha_wr_decode #(
    .KEY_WORDS  (KEY_WORDS),
    .DATA_WORDS (DATA_WORDS)
  ) u_dec (
    .wr_en   (host.i_wr_en),
    .wr_addr (host.i_wr_addr),
    .key_we  (key_we),
    .data_we (data_we),
    .ctrl_we (ctrl_we),
    .illegal (illegal)
  );

  assign in_idle    = (state_q == IDLE);
  assign start_rise = host.i_start && !start_q;
  assign launch     = in_idle && start_rise;
  // A same-cycle control write must steer the launch, so bypass the register
  assign aes_eff    = ctrl_we ? host.i_wr_data[CTRL_AES_BIT] : aes_q;
  assign reject     = (!in_idle && (host.i_wr_en || start_rise)) || (in_idle && illegal);

  // Operand registers: written only in IDLE so the control unit sees stable inputs
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      key_q  <= '0;
      data_q <= '0;
      aes_q  <= 1'b0;
      dec_q  <= 1'b0;
    end else if (in_idle) begin
      for (int k = 0; k < KEY_WORDS; k++) begin
        if (key_we[k]) key_q[32*k +: 32] <= host.i_wr_data;
      end
      for (int j = 0; j < DATA_WORDS; j++) begin
        if (data_we[j]) data_q[32*j +: 32] <= host.i_wr_data;
      end
      if (ctrl_we) begin
        aes_q <= host.i_wr_data[CTRL_AES_BIT];
        dec_q <= host.i_wr_data[CTRL_DEC_BIT];
      end
    end
  end

  // FSM state register
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = ARM;
      ARM:     state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM output decode
  always_comb begin
    busy_d = (state_d == ARM) || (state_d == RUN);
    done   = (state_q == DONE);
  end

  // Down-counter: loaded on launch so ARM already holds N-1 and DONE lands N cycles after release
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_q <= '0;
    end else if (launch) begin
      cnt_q <= aes_eff ? CW'(AES_CYCLES - 1) : CW'(KECCAK_CYCLES - 1);
    end else if (((state_q == ARM) || (state_q == RUN)) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Registered status: control-unit reset, busy, error pulse and start edge history
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cu_rst_n_q <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      cu_rst_n_q <= busy_d;
      busy_q     <= busy_d;
      err_q      <= reject;
      start_q    <= host.i_start;
    end
  end

  assign o_key           = key_q;
  assign o_data          = data_q;
  assign o_aes_or_keccak = aes_q;
  assign o_enc_or_dec    = dec_q;
  assign o_cu_reset_n    = cu_rst_n_q;
  assign o_state         = state_q;
  assign host.o_busy     = busy_q;
  assign host.o_done     = done;
  assign host.o_wr_err   = err_q;

endmodule

// File: tb/tb_aesha_input_loader.sv
// Self-checking bench for aesha_input_loader.
module tb_aesha_input_loader;
  import aesha_pkg::*;

  localparam int AES_N = 44;
  localparam int KEC_N = 26;

  // ---------------- clock / reset ----------------
  logic i_clk = 1'b0;
  logic i_reset;
  always #5 i_clk = ~i_clk;

  aesha_input_loader_if host();
  logic [127:0] o_key;
  logic [511:0] o_data;
  logic         o_aes_or_keccak, o_enc_or_dec, o_cu_reset_n;
  state_t       o_state;

  aesha_input_loader dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .host            (host),
    .o_key           (o_key),
    .o_data          (o_data),
    .o_aes_or_keccak (o_aes_or_keccak),
    .o_enc_or_dec    (o_enc_or_dec),
    .o_cu_reset_n    (o_cu_reset_n),
    .o_state         (o_state)
  );

  // ---------------- reference model / scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] key_m [4];
  logic [31:0] data_m [16];
  bit aes_m, dec_m;
  logic [7:0] exp_q[$];   // expected release-to-done latency of each launch

  function automatic logic [127:0] model_key();
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[32*k +: 32] = key_m[k];
    return r;
  endfunction

  function automatic logic [511:0] model_data();
    logic [511:0] r;
    for (int j = 0; j < 16; j++) r[32*j +: 32] = data_m[j];
    return r;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) key_m[k] = '0;
    for (int j = 0; j < 16; j++) data_m[j] = '0;
    aes_m = 1'b0;
    dec_m = 1'b0;
  endtask

  // Applies an IDLE write to the model; returns 1 when the address is mapped
  function automatic bit model_write(input int a, input logic [31:0] d);
    if (a < 4) begin
      key_m[a] = d;
    end else if (a < 20) begin
      data_m[a-4] = d;
    end else if (a == 20) begin
      aes_m = d[0];
      dec_m = d[1];
    end else begin
      return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_key"},  512'(o_key),  512'(model_key()));
    chk({tag, "_data"}, o_data,       model_data());
    chk({tag, "_aes"},  512'(o_aes_or_keccak), 512'(aes_m));
    chk({tag, "_dec"},  512'(o_enc_or_dec),    512'(dec_m));
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic host_write(input int a, input logic [31:0] d);
    bit legal;
    host.i_wr_en   = 1'b1;
    host.i_wr_addr = 5'(a);
    host.i_wr_data = d;
    tick();
    host.i_wr_en = 1'b0;
    legal = model_write(a, d);
    chk("wr_err", 512'(host.o_wr_err), 512'(!legal));
    check_regs("wr");
  endtask

  // One launch; inject>0 adds a data write and a start pulse mid-run,
  // hold keeps i_start high throughout, ctrl_wr>=0 writes control with start.
  task automatic run_op(input int inject, input bit hold, input int ctrl_wr);
    int n, errs, dones;
    logic [7:0] lat;
    chk("pre_launch_rst_n", 512'(o_cu_reset_n), 512'(0));
    host.i_start = 1'b1;
    if (ctrl_wr >= 0) begin
      host.i_wr_en   = 1'b1;
      host.i_wr_addr = 5'd20;
      host.i_wr_data = 32'(ctrl_wr);
      void'(model_write(20, 32'(ctrl_wr)));
    end
    exp_q.push_back(aes_m ? 8'(AES_N) : 8'(KEC_N));
    tick();
    host.i_wr_en = 1'b0;
    if (!hold) host.i_start = 1'b0;
    chk("launch_rst_n", 512'(o_cu_reset_n), 512'(1));
    chk("launch_busy",  512'(host.o_busy),  512'(1));
    n = 0;
    errs = 0;
    while (!host.o_done && n < 200) begin
      if (inject > 0 && n == inject) begin
        host.i_wr_en   = 1'b1;
        host.i_wr_addr = 5'd4;
        host.i_wr_data = 32'hDEADBEEF;
      end
      if (inject > 0 && n == inject + 3) host.i_start = 1'b1;
      tick();
      n++;
      host.i_wr_en = 1'b0;
      if (!hold) host.i_start = 1'b0;
      if (host.o_wr_err) errs++;
      if (n == 10) chk("run_busy", 512'(host.o_busy), 512'(1));
    end
    lat = exp_q.pop_front();
    chk("done_latency", 512'(n), 512'(lat));
    chk("done_busy",    512'(host.o_busy),  512'(0));
    chk("done_rst_n",   512'(o_cu_reset_n), 512'(0));
    if (!hold) chk("wr_err_count", 512'(errs), 512'((inject > 0) ? 2 : 0));
    check_regs("post_op");
    dones = 0;
    repeat (6) begin
      tick();
      if (host.o_done) dones++;
    end
    chk("extra_done", 512'(dones), 512'(0));
    chk("idle_busy",  512'(host.o_busy), 512'(0));
    chk("idle_state", 512'(o_state), 512'(IDLE));
    host.i_start = 1'b0;
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int dones;
    host.i_wr_en   = 1'b0;
    host.i_wr_addr = '0;
    host.i_wr_data = '0;
    host.i_start   = 1'b0;
    model_clear();
    i_reset = 1'b1;
    tick();
    tick();
    i_reset = 1'b0;

    // Idle after reset: control unit held in reset, registers cleared
    repeat (10) begin
      tick();
      chk("rst_cu_reset_n", 512'(o_cu_reset_n), 512'(0));
      chk("rst_busy",       512'(host.o_busy),  512'(0));
      chk("rst_key",        512'(o_key),        512'(0));
      chk("rst_data",       o_data,             512'(0));
    end

    // Directed load: byte-ramp key, index data, AES mode
    for (int k = 0; k < 4; k++)
      host_write(k, {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)});
    for (int j = 0; j < 16; j++) host_write(4 + j, 32'(4 + j));
    host_write(20, 32'h1);
    chk("key_ramp", 512'(o_key), 512'(128'h0F0E0D0C_0B0A0908_07060504_03020100));
    run_op(0, 1'b0, -1);

    // Keccak length
    host_write(20, 32'h0);
    run_op(0, 1'b0, -1);

    // Write and start rejected during RUN
    run_op(5, 1'b0, -1);

    // Unmapped address in IDLE
    host_write(25, $urandom);
    tick();
    chk("illegal_err_clear", 512'(host.o_wr_err), 512'(0));
    check_regs("illegal");

    // Random writes over the whole address space, then a launch
    repeat (40) host_write(int'($urandom_range(0, 31)), $urandom);
    run_op(0, 1'b0, -1);

    // Control write in the same cycle as start steers the length
    repeat (2) run_op(0, 1'b0, int'({1'($urandom_range(0, 1)), !aes_m}));

    // Start held high launches once
    run_op(0, 1'b1, -1);

    // Reset 10 cycles into RUN aborts the operation
    host.i_start = 1'b1;
    tick();
    host.i_start = 1'b0;
    repeat (11) tick();
    chk("pre_abort_busy", 512'(host.o_busy), 512'(1));
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    model_clear();
    chk("abort_rst_n", 512'(o_cu_reset_n), 512'(0));
    chk("abort_busy",  512'(host.o_busy),  512'(0));
    chk("abort_state", 512'(o_state),      512'(IDLE));
    check_regs("abort");
    dones = 0;
    repeat (60) begin
      tick();
      if (host.o_done) dones++;
    end
    chk("abort_no_done", 512'(dones), 512'(0));

    // Fresh operation after the abort
    repeat (8) host_write(int'($urandom_range(0, 20)), $urandom);
    run_op(0, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
